// File: rtl/ip_recv.sv
// ip_recv: receive-side IPv4 parser. Validates the header as it streams past, decides at the
// last header byte, then forwards exactly payload_length bytes and discards any Ethernet pad.
module ip_recv #(
  parameter bit ACCEPT_BCAST = 1'b1,
  parameter bit CHECK_CSUM   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_enable,
  input  logic [7:0]  data_in,
  input  logic [31:0] local_ip,
  output logic        active,
  output logic        header_ok,
  output logic        is_icmp,
  output logic        is_udp,
  output logic [31:0] remote_ip,
  output logic        to_bcast,
  output logic [15:0] payload_length,
  output logic        payload_valid,
  output logic [7:0]  data_out,
  output logic        drop
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_WAIT    = 2'd3;

  // One's-complement add with the end-around carry folded back immediately.
  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
    logic [16:0] sum;
    sum = {1'b0, acc} + {1'b0, word};
    return sum[15:0] + {15'd0, sum[16]};
  endfunction

  logic [1:0]  state_r;
  logic [5:0]  byte_no_r;
  logic [7:0]  prev_r;
  logic [15:0] csum_r;
  logic        bad_r;
  logic [3:0]  ihl_r;
  logic [15:0] total_len_r;
  logic [7:0]  proto_r;
  logic [31:0] src_r;
  logic [31:0] dst_r;
  logic [15:0] pay_cnt_r;

  logic [15:0] csum_s;
  logic [31:0] dst_s;
  logic [5:0]  hdr_end_s;
  logic        hdr_last_s;
  logic        byte_bad_s;
  logic        dst_ok_s;
  logic        hdr_fail_s;
  logic [15:0] plen_s;

  // Per-byte header checks and the end-of-header verdict, including the byte now on data_in.
  always_comb begin
    if (byte_no_r >= 6'd3 && byte_no_r[0]) csum_s = csum_add(csum_r, {prev_r, data_in});
    else csum_s = csum_r;
    if (byte_no_r >= 6'd18 && byte_no_r <= 6'd21) dst_s = {dst_r[23:0], data_in};
    else dst_s = dst_r;
    case (byte_no_r)
      6'd1:    byte_bad_s = ({prev_r, data_in} != 16'h0800);
      6'd2:    byte_bad_s = (data_in[7:4] != 4'd4);
      6'd8:    byte_bad_s = (data_in[5:0] != 6'd0);
      6'd9:    byte_bad_s = (data_in != 8'd0);
      6'd11:   byte_bad_s = (data_in != 8'd1) && (data_in != 8'd17);
      default: byte_bad_s = 1'b0;
    endcase
    // A bogus IHL below 5 still ends the header after the minimum 20 IP bytes.
    hdr_end_s  = (ihl_r < 4'd5) ? 6'd21 : ({ihl_r, 2'b00} + 6'd1);
    hdr_last_s = (byte_no_r >= 6'd21) && (byte_no_r == hdr_end_s);
    dst_ok_s   = (dst_s == local_ip) || (ACCEPT_BCAST && (dst_s == 32'hFFFF_FFFF));
    plen_s     = total_len_r - {10'd0, ihl_r, 2'b00};
    hdr_fail_s = bad_r || byte_bad_s || (ihl_r < 4'd5) ||
                 (total_len_r < {10'd0, ihl_r, 2'b00}) || !dst_ok_s ||
                 (CHECK_CSUM && (csum_s != 16'hFFFF));
  end

  // Frame FSM, header field capture and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_WAIT;
      byte_no_r      <= 6'd0;
      prev_r         <= 8'd0;
      csum_r         <= 16'd0;
      bad_r          <= 1'b0;
      ihl_r          <= 4'd0;
      total_len_r    <= 16'd0;
      proto_r        <= 8'd0;
      src_r          <= 32'd0;
      dst_r          <= 32'd0;
      pay_cnt_r      <= 16'd0;
      active         <= 1'b0;
      header_ok      <= 1'b0;
      is_icmp        <= 1'b0;
      is_udp         <= 1'b0;
      remote_ip      <= 32'd0;
      to_bcast       <= 1'b0;
      payload_length <= 16'd0;
      payload_valid  <= 1'b0;
      data_out       <= 8'd0;
      drop           <= 1'b0;
    end else begin
      drop          <= 1'b0;
      payload_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rx_enable) begin
            active    <= 1'b1;
            byte_no_r <= 6'd1;
            prev_r    <= data_in;
            csum_r    <= 16'd0;
            bad_r     <= 1'b0;
            state_r   <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!rx_enable) begin
            drop    <= 1'b1;
            active  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            byte_no_r <= byte_no_r + 6'd1;
            prev_r    <= data_in;
            csum_r    <= csum_s;
            bad_r     <= bad_r | byte_bad_s;
            dst_r     <= dst_s;
            if (byte_no_r == 6'd2) ihl_r <= data_in[3:0];
            if (byte_no_r == 6'd4) total_len_r[15:8] <= data_in;
            if (byte_no_r == 6'd5) total_len_r[7:0] <= data_in;
            if (byte_no_r == 6'd11) proto_r <= data_in;
            if (byte_no_r >= 6'd14 && byte_no_r <= 6'd17) src_r <= {src_r[23:0], data_in};
            if (hdr_last_s) begin
              if (hdr_fail_s) begin
                drop    <= 1'b1;
                state_r <= ST_WAIT;
              end else begin
                header_ok      <= 1'b1;
                is_icmp        <= (proto_r == 8'd1);
                is_udp         <= (proto_r == 8'd17);
                remote_ip      <= src_r;
                to_bcast       <= (dst_s == 32'hFFFF_FFFF);
                payload_length <= plen_s;
                pay_cnt_r      <= 16'd0;
                state_r        <= (plen_s == 16'd0) ? ST_WAIT : ST_PAYLOAD;
              end
            end
          end
        end
        ST_PAYLOAD: begin
          if (!rx_enable) begin
            drop      <= 1'b1;
            header_ok <= 1'b0;
            active    <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            payload_valid <= 1'b1;
            data_out      <= data_in;
            pay_cnt_r     <= pay_cnt_r + 16'd1;
            if (pay_cnt_r + 16'd1 == payload_length) state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!rx_enable) begin
            header_ok <= 1'b0;
            active    <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: state_r <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_recv.sv
// tb_ip_recv: three ip_recv instances (default, checksum ignored, no broadcast) share one byte
// stream; each frame is judged by a byte-level reference model and compared after the frame.
module tb_ip_recv;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_enable;
  logic [7:0]  data_in;
  logic [31:0] local_ip;

  logic        active_v [3];
  logic        header_ok_v [3];
  logic        is_icmp_v [3];
  logic        is_udp_v [3];
  logic [31:0] remote_ip_v [3];
  logic        to_bcast_v [3];
  logic [15:0] payload_length_v [3];
  logic        payload_valid_v [3];
  logic [7:0]  data_out_v [3];
  logic        drop_v [3];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ip_recv #(.ACCEPT_BCAST(g != 2), .CHECK_CSUM(g != 1)) dut (
      .clock(clock), .reset(reset), .rx_enable(rx_enable), .data_in(data_in),
      .local_ip(local_ip), .active(active_v[g]), .header_ok(header_ok_v[g]),
      .is_icmp(is_icmp_v[g]), .is_udp(is_udp_v[g]), .remote_ip(remote_ip_v[g]),
      .to_bcast(to_bcast_v[g]), .payload_length(payload_length_v[g]),
      .payload_valid(payload_valid_v[g]), .data_out(data_out_v[g]), .drop(drop_v[g])
    );
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Running activity totals per instance; frames are judged on deltas.
  int          pv_total [3]  = '{0, 0, 0};
  int          drop_total [3] = '{0, 0, 0};
  int          act_total [3] = '{0, 0, 0};
  int          hok_rises [3] = '{0, 0, 0};
  int          order_bad [3] = '{0, 0, 0};
  bit          hok_prev [3]  = '{0, 0, 0};
  logic [7:0]  pbuf [3][1024];
  logic        cap_icmp [3], cap_udp [3], cap_bcast [3];
  logic [31:0] cap_rip [3];
  logic [15:0] cap_plen [3];

  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (payload_valid_v[k] === 1'b1) begin
        pbuf[k][pv_total[k] % 1024] = data_out_v[k];
        pv_total[k] = pv_total[k] + 1;
        if (header_ok_v[k] !== 1'b1) order_bad[k] = order_bad[k] + 1;
      end
      if (drop_v[k] === 1'b1) drop_total[k] = drop_total[k] + 1;
      if (active_v[k] === 1'b1) act_total[k] = act_total[k] + 1;
      if (header_ok_v[k] === 1'b1 && !hok_prev[k]) begin
        hok_rises[k] = hok_rises[k] + 1;
        cap_icmp[k]  = is_icmp_v[k];
        cap_udp[k]   = is_udp_v[k];
        cap_bcast[k] = to_bcast_v[k];
        cap_rip[k]   = remote_ip_v[k];
        cap_plen[k]  = payload_length_v[k];
      end
      hok_prev[k] = (header_ok_v[k] === 1'b1);
    end
  end

  logic [7:0] fr [$];

  function automatic logic [15:0] ones_sum(input int from, input int to);
    int unsigned s;
    s = 0;
    for (int i = from; i < to; i += 2) s += {16'd0, fr[i], fr[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  task automatic fix_csum();
    logic [7:0]  b2;
    logic [15:0] cs;
    int          ihl;
    b2 = fr[2];
    ihl = int'(b2[3:0]);
    fr[12] = 8'h00;
    fr[13] = 8'h00;
    cs = ~ones_sum(2, (ihl >= 5) ? 2 + ihl * 4 : 22);
    fr[12] = cs[15:8];
    fr[13] = cs[7:0];
  endtask

  task automatic build(input int ihl, input int proto, input logic [31:0] dst,
                       input int plen, input int pad);
    logic [15:0] tl;
    logic [31:0] src;
    tl = 16'(ihl * 4 + plen);
    src = $urandom;
    fr.delete();
    fr.push_back(8'h08); fr.push_back(8'h00);
    fr.push_back({4'd4, 4'(ihl)}); fr.push_back(8'h00);
    fr.push_back(tl[15:8]); fr.push_back(tl[7:0]);
    fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
    fr.push_back(($urandom_range(0, 1) != 0) ? 8'h40 : 8'h00); fr.push_back(8'h00);
    fr.push_back(8'h40); fr.push_back(8'(proto)); fr.push_back(8'h00); fr.push_back(8'h00);
    for (int i = 3; i >= 0; i--) fr.push_back(src[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) fr.push_back(dst[i*8 +: 8]);
    for (int i = 0; i < (ihl - 5) * 4; i++) fr.push_back(8'($urandom));
    for (int i = 0; i < plen + pad; i++) fr.push_back(8'($urandom));
    fix_csum();
  endtask

  task automatic load_spec(input int pad);
    logic [7:0] hdr [22];
    hdr = '{8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80,
            8'h11, 8'hB7, 8'h1B, 8'hC0, 8'hA8, 8'h01, 8'h01, 8'hC0, 8'hA8, 8'h01, 8'h64};
    fr.delete();
    for (int i = 0; i < 22; i++) fr.push_back(hdr[i]);
    for (int i = 0; i < 8 + pad; i++) fr.push_back(8'($urandom));
  endtask

  // Drive the first n bytes of fr, drop rx_enable, then judge every instance against the model.
  task automatic run_frame(input int n, input int gap);
    int          b_pv [3], b_dr [3], b_hr [3], b_ob [3];
    int          ihl, hl, tl, plen, npay;
    logic [7:0]  b2;
    logic [31:0] dst;
    bit          common, ok, exp_drop;
    for (int k = 0; k < 3; k++) begin
      b_pv[k] = pv_total[k]; b_dr[k] = drop_total[k];
      b_hr[k] = hok_rises[k]; b_ob[k] = order_bad[k];
    end
    for (int i = 0; i < n; i++) begin
      rx_enable = 1'b1;
      data_in = fr[i];
      @(posedge clock); #1;
    end
    rx_enable = 1'b0;
    data_in = 8'h00;
    @(posedge clock); @(negedge clock); #1;
    b2 = fr[2];
    ihl = int'(b2[3:0]);
    hl = (ihl >= 5) ? 2 + ihl * 4 : 22;
    tl = int'({fr[4], fr[5]});
    dst = {fr[18], fr[19], fr[20], fr[21]};
    common = ({fr[0], fr[1]} == 16'h0800) && (b2[7:4] == 4'd4) && (ihl >= 5) &&
             (fr[11] == 8'd1 || fr[11] == 8'd17) && ((fr[8] & 8'h3F) == 8'h00) &&
             (fr[9] == 8'h00) && (tl >= ihl * 4) && (n >= hl);
    for (int k = 0; k < 3; k++) begin
      ok = common && (dst == local_ip || (k != 2 && dst == 32'hFFFF_FFFF)) &&
           (k == 1 || ones_sum(2, hl) == 16'hFFFF);
      plen = ok ? tl - ihl * 4 : 0;
      npay = (ok && n - hl < plen) ? n - hl : plen;
      exp_drop = !ok || (n - hl < plen);
      check_eq($sformatf("hdr_ok_rise[%0d]", k), 32'(hok_rises[k] - b_hr[k]), 32'(ok));
      check_eq($sformatf("drops[%0d]", k), 32'(drop_total[k] - b_dr[k]), 32'(exp_drop));
      check_eq($sformatf("pay_count[%0d]", k), 32'(pv_total[k] - b_pv[k]), 32'(npay));
      check_eq($sformatf("pay_before_hdr[%0d]", k), 32'(order_bad[k] - b_ob[k]), 32'd0);
      check_eq($sformatf("hdr_ok_after[%0d]", k), 32'(header_ok_v[k]), 32'd0);
      check_eq($sformatf("active_after[%0d]", k), 32'(active_v[k]), 32'd0);
      if (ok) begin
        check_eq($sformatf("is_udp[%0d]", k), 32'(cap_udp[k]), 32'(fr[11] == 8'd17));
        check_eq($sformatf("is_icmp[%0d]", k), 32'(cap_icmp[k]), 32'(fr[11] == 8'd1));
        check_eq($sformatf("remote_ip[%0d]", k), cap_rip[k], {fr[14], fr[15], fr[16], fr[17]});
        check_eq($sformatf("to_bcast[%0d]", k), 32'(cap_bcast[k]), 32'(dst == 32'hFFFF_FFFF));
        check_eq($sformatf("pay_len[%0d]", k), 32'(cap_plen[k]), 32'(plen));
        for (int j = 0; j < npay; j++)
          check_eq($sformatf("pay_byte[%0d][%0d]", k, j),
                   32'(pbuf[k][(b_pv[k] + j) % 1024]), 32'(fr[hl + j]));
      end
    end
    repeat (gap - 1) begin @(posedge clock); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s_active[%0d]", tag, k), 32'(active_v[k]), 32'd0);
      check_eq($sformatf("%s_hdr_ok[%0d]", tag, k), 32'(header_ok_v[k]), 32'd0);
      check_eq($sformatf("%s_pv[%0d]", tag, k), 32'(payload_valid_v[k]), 32'd0);
      check_eq($sformatf("%s_drop[%0d]", tag, k), 32'(drop_v[k]), 32'd0);
      check_eq($sformatf("%s_fields[%0d]", tag, k),
               remote_ip_v[k] | {16'd0, payload_length_v[k]} | {24'd0, data_out_v[k]} |
               {29'd0, is_icmp_v[k], is_udp_v[k], to_bcast_v[k]}, 32'd0);
    end
  endtask

  // Reset lands on header byte 10 and is released two bytes later while the frame continues.
  task automatic reset_mid_frame();
    int b_pv [3], b_dr [3], b_hr [3], b_ac [3];
    load_spec(0);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == 10) reset = 1'b1;
      if (i == 12) reset = 1'b0;
      rx_enable = 1'b1;
      data_in = fr[i];
      @(posedge clock); #1;
      if (i == 10) begin
        check_reset_outputs("midrst");
        for (int k = 0; k < 3; k++) begin
          b_pv[k] = pv_total[k]; b_dr[k] = drop_total[k];
          b_hr[k] = hok_rises[k]; b_ac[k] = act_total[k];
        end
      end
    end
    rx_enable = 1'b0;
    @(posedge clock); @(negedge clock); #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst_pv[%0d]", k), 32'(pv_total[k] - b_pv[k]), 32'd0);
      check_eq($sformatf("rst_drop[%0d]", k), 32'(drop_total[k] - b_dr[k]), 32'd0);
      check_eq($sformatf("rst_hok[%0d]", k), 32'(hok_rises[k] - b_hr[k]), 32'd0);
      check_eq($sformatf("rst_active[%0d]", k), 32'(act_total[k] - b_ac[k]), 32'd0);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rx_enable = 1'b0;
    data_in = 8'h00;
    local_ip = 32'hC0A8_0164;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    load_spec(0);  run_frame(fr.size(), 2);
    load_spec(18); run_frame(fr.size(), 2);
    load_spec(0);  fr[13] = 8'h1C; run_frame(fr.size(), 2);
    load_spec(0);
    for (int i = 18; i < 22; i++) fr[i] = 8'hFF;
    fix_csum();    run_frame(fr.size(), 2);
    load_spec(0);  fr[1] = 8'h06; fix_csum(); run_frame(fr.size(), 2);
    build(6, 17, local_ip, 4, 0); run_frame(fr.size(), 2);
    load_spec(0);  fr[8] = 8'h20; fix_csum(); run_frame(fr.size(), 2);
    build(5, 1, local_ip, 0, 6);  run_frame(fr.size(), 1);
    build(15, 17, local_ip, 3, 2); run_frame(fr.size(), 1);

    reset_mid_frame();
    load_spec(4);  run_frame(fr.size(), 1);
    load_spec(0);  run_frame(15, 2);

    for (int f = 0; f < 150; f++) begin
      int          ihl, sel, n;
      logic [31:0] dst;
      logic [7:0]  b;
      ihl = ($urandom_range(0, 15) == 0) ? 4 : int'($urandom_range(5, 8));
      sel = int'($urandom_range(0, 9));
      dst = (sel < 6) ? local_ip : ((sel < 8) ? 32'hFFFF_FFFF : $urandom);
      build(ihl, ($urandom_range(0, 9) == 0) ? 6 : (($urandom_range(0, 1) != 0) ? 17 : 1),
            dst, int'($urandom_range(0, 24)), int'($urandom_range(0, 20)));
      case ($urandom_range(0, 11))
        0: fr[1] = 8'h06;
        1: fr[8] = 8'h20;
        2: fr[9] = 8'h01;
        3: begin b = fr[2]; b[7:4] = 4'd6; fr[2] = b; end
        4: begin fr[4] = 8'h00; fr[5] = 8'd8; end
        default: ;
      endcase
      fix_csum();
      if ($urandom_range(0, 7) == 0) fr[13] = fr[13] ^ 8'h01;
      n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, fr.size())) : fr.size();
      run_frame(n, int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
